// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares the single data memory of the multicycle i281 CPU
//               between the CPU control path (port "cpu") and the debug /
//               program-loader path (port "dbg"). Serialises accesses with a
//               last-granted tie-break, absorbs memory read latency and
//               returns a one-cycle done pulse to the owning requester.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock, reset           : clock; asynchronous active-high reset
//   cpu_req/we/addr/wdata  : CPU request, held until cpu_done
//   cpu_done, cpu_rdata    : CPU completion pulse, last CPU read data
//   cpu_stall              : cpu_req & ~cpu_done, holds the control FSM
//   dbg_req/we/addr/wdata  : debug request, same semantics as the CPU port
//   dbg_done, dbg_rdata    : debug completion pulse, last debug read data
//   dbg_lock               : blocks new CPU grants while high
//   mem_en/we/addr/wdata   : memory strobe, write enable, address, data
//   mem_rdata              : memory read data, READ_LAT cycles after mem_en
//   busy                   : arbiter is not idle
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_done,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              dbg_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  // WAIT is entered with the number of extra cycles still to wait; the
  // capture happens in the WAIT cycle that sees zero.
  localparam logic [1:0] LAT_LOAD = (READ_LAT > 0) ? 2'(READ_LAT - 1) : 2'd0;

  logic [1:0] state;
  logic       owner;
  logic       last_gnt;
  logic       acc_we;
  logic [1:0] lat_cnt;

  logic elig_cpu;
  logic elig_dbg;
  logic grant_any;
  logic grant_dbg;
  logic capture;

  // Arbitration: only an eligible requester can win; on a tie the port that
  // was not granted last time goes first, so neither can starve the other.
  always_comb begin
    elig_cpu  = cpu_req & ~dbg_lock;
    elig_dbg  = dbg_req;
    grant_any = elig_cpu | elig_dbg;
    grant_dbg = elig_dbg & (~elig_cpu | (last_gnt == OWN_CPU));
  end

  // Read data is taken either straight out of ACC (zero latency) or in the
  // last WAIT cycle.
  always_comb begin
    capture = 1'b0;
    if (state == S_ACC && !acc_we && READ_LAT == 0) begin
      capture = 1'b1;
    end else if (state == S_WAIT && lat_cnt == 2'd0) begin
      capture = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      owner     <= OWN_CPU;
      last_gnt  <= OWN_DBG;
      acc_we    <= 1'b0;
      lat_cnt   <= 2'd0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            owner     <= grant_dbg;
            last_gnt  <= grant_dbg;
            acc_we    <= grant_dbg ? dbg_we    : cpu_we;
            mem_addr  <= grant_dbg ? dbg_addr  : cpu_addr;
            mem_wdata <= grant_dbg ? dbg_wdata : cpu_wdata;
            state     <= S_ACC;
          end
        end
        S_ACC: begin
          if (acc_we || READ_LAT == 0) begin
            state <= S_DONE;
          end else begin
            lat_cnt <= LAT_LOAD;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_cnt == 2'd0) begin
            state <= S_DONE;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Only the owner's read register is written; the other port keeps its
  // last value across a foreign access.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else if (capture) begin
      if (owner == OWN_DBG) begin
        dbg_rdata <= mem_rdata;
      end else begin
        cpu_rdata <= mem_rdata;
      end
    end
  end

  always_comb begin
    mem_en    = (state == S_ACC);
    mem_we    = (state == S_ACC) & acc_we;
    busy      = (state != S_IDLE);
    cpu_done  = (state == S_DONE) & (owner == OWN_CPU);
    dbg_done  = (state == S_DONE) & (owner == OWN_DBG);
    cpu_stall = cpu_req & ~cpu_done;
  end

endmodule
`default_nettype wire
